// File: rtl/avmm_lat_ram_if.sv
// Avalon-MM slave bus bundle for avmm_lat_ram.
// Ports: address/read/write/byteenable/writedata from master; waitrequest/readdata/readdatavalid from slave.
interface avmm_lat_ram_if #(
    parameter int ADDR_W = 11
) ();
    logic [ADDR_W-1:0] avs_address_i;
    logic              avs_read_i;
    logic              avs_write_i;
    logic [1:0]        avs_byteenable_i;
    logic [15:0]       avs_writedata_i;
    logic              avs_waitrequest_o;
    logic [15:0]       avs_readdata_o;
    logic              avs_readdatavalid_o;

    modport master (
        output avs_address_i,
        output avs_read_i,
        output avs_write_i,
        output avs_byteenable_i,
        output avs_writedata_i,
        input  avs_waitrequest_o,
        input  avs_readdata_o,
        input  avs_readdatavalid_o
    );

    modport slave (
        input  avs_address_i,
        input  avs_read_i,
        input  avs_write_i,
        input  avs_byteenable_i,
        input  avs_writedata_i,
        output avs_waitrequest_o,
        output avs_readdata_o,
        output avs_readdatavalid_o
    );
endinterface

// File: rtl/avmm_lat_ram.sv
// 16-bit word RAM behind an Avalon-MM slave with fixed wait states and read latency.
// Ports: clk_i, rst_i (sync, active-high), bus (avmm_lat_ram_if.slave), err_o (sticky protocol error).
module avmm_lat_ram #(
    parameter int ADDR_W      = 11,
    parameter int WAIT_CYCLES = 2,
    parameter int RD_LATENCY  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    avmm_lat_ram_if.slave        bus,
    output logic                 err_o
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCEPT
    } state_t;

    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        stall;
    logic        err;

    logic [15:0] mem [2**ADDR_W];

    logic [RD_LATENCY-1:0] pv;
    logic [15:0]           pd [RD_LATENCY];

    logic req;
    logic acc;
    logic rd_acc;
    logic wr_acc;

    assign req    = bus.avs_read_i | bus.avs_write_i;
    assign acc    = (state == S_ACCEPT);
    // A read+write collision commits as a write only.
    assign wr_acc = acc & bus.avs_write_i;
    assign rd_acc = acc & bus.avs_read_i & ~bus.avs_write_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            stall <= 1'b1;
            err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= S_ACCEPT;
                            stall <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        // Master gave up mid-stall: abort, flag it.
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        state <= S_ACCEPT;
                        stall <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACCEPT: begin
                    state <= S_IDLE;
                    stall <= 1'b1;
                    if (bus.avs_read_i && bus.avs_write_i) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    stall <= 1'b1;
                end
            endcase
        end
    end

    // Memory is never cleared; reset only blocks the commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) begin
            if (bus.avs_byteenable_i[0]) begin
                mem[bus.avs_address_i][7:0] <= bus.avs_writedata_i[7:0];
            end
            if (bus.avs_byteenable_i[1]) begin
                mem[bus.avs_address_i][15:8] <= bus.avs_writedata_i[15:8];
            end
        end
    end

    // Each data stage loads only behind a valid, so the last stage
    // doubles as the held readdata register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pv <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc) begin
                pd[0] <= mem[bus.avs_address_i];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign bus.avs_waitrequest_o   = stall;
    assign bus.avs_readdatavalid_o = pv[RD_LATENCY-1];
    assign bus.avs_readdata_o      = pd[RD_LATENCY-1];
    assign err_o                   = err;
endmodule

// File: tb/tb_avmm_lat_ram.sv
// Self-checking bench for avmm_lat_ram: cycle model plus directed vectors.
// Ports: none (drives clk, rst and an avmm_lat_ram_if instance).
module tb_avmm_lat_ram;
    localparam int AW = 11;
    localparam int W  = 2;
    localparam int L  = 2;

    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    avmm_lat_ram_if #(.ADDR_W(AW)) bus ();

    avmm_lat_ram #(
        .ADDR_W(AW),
        .WAIT_CYCLES(W),
        .RD_LATENCY(L)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: el counts cycles since a command was first seen in idle;
    // the command is taken when el reaches W+1.
    int          cyc = 0;
    int          el = -1;
    bit          m_err = 1'b0;
    logic [15:0] m_last = '0;
    logic [15:0] mm [2**AW];
    rd_t         q[$];
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        rd_t e;
        logic r;
        logic w;
        logic [AW-1:0] a;
        r = bus.avs_read_i;
        w = bus.avs_write_i;
        a = bus.avs_address_i;
        if (rst) begin
            el = -1;
            m_err = 1'b0;
            q.delete();
            m_last = '0;
            chk_en = 1'b1;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                m_last = q[0].d;
                void'(q.pop_front());
            end
            if (el == W + 1) begin
                if (w) begin
                    if (bus.avs_byteenable_i[0]) mm[a][7:0] = bus.avs_writedata_i[7:0];
                    if (bus.avs_byteenable_i[1]) mm[a][15:8] = bus.avs_writedata_i[15:8];
                end
                if (r && w) begin
                    m_err = 1'b1;
                end else if (r) begin
                    e.due = cyc + L;
                    e.d = mm[a];
                    q.push_back(e);
                end
                el = -1;
            end else if (el >= 1) begin
                if (!(r || w)) begin
                    m_err = 1'b1;
                    el = -1;
                end else begin
                    el++;
                end
            end else if (r || w) begin
                el = 1;
            end
        end
        cyc++;
    end

    logic [15:0] got[$];
    int          got_cyc[$];

    always @(negedge clk) begin
        bit ev;
        logic [15:0] ed;
        if (chk_en) begin
            ev = (q.size() > 0 && q[0].due == cyc);
            ed = ev ? q[0].d : m_last;
            chk("waitrequest", bus.avs_waitrequest_o, (el == W + 1) ? 0 : 1);
            chk("readdatavalid", bus.avs_readdatavalid_o, ev);
            chk("readdata", bus.avs_readdata_o, ed);
            chk("err", err, m_err);
            if (bus.avs_readdatavalid_o) begin
                got.push_back(bus.avs_readdata_o);
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic idle();
        bus.avs_read_i = 1'b0;
        bus.avs_write_i = 1'b0;
        bus.avs_byteenable_i = 2'b00;
        bus.avs_writedata_i = '0;
        bus.avs_address_i = '0;
    endtask

    task automatic issue(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [1:0] be, input logic [15:0] d,
                         input bit rst_acc, output int lat, output int acc);
        bus.avs_read_i = r;
        bus.avs_write_i = w;
        bus.avs_address_i = a;
        bus.avs_byteenable_i = be;
        bus.avs_writedata_i = d;
        lat = 0;
        acc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest_o) begin
                acc = cyc;
                break;
            end
            lat++;
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        if (rst_acc) rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wr_word(input logic [AW-1:0] a, input logic [1:0] be,
                           input logic [15:0] d);
        int lat;
        int acc;
        issue(1'b0, 1'b1, a, be, d, 1'b0, lat, acc);
        idle();
    endtask

    task automatic rd_expect(string nm, input logic [AW-1:0] a,
                             input logic [15:0] exp);
        int lat;
        int acc;
        int n0;
        n0 = got.size();
        issue(1'b1, 1'b0, a, 2'b00, 16'h0, 1'b0, lat, acc);
        idle();
        repeat (L + 2) @(posedge clk);
        #1;
        chk({nm, "_lat"}, lat, W + 1);
        chk({nm, "_cnt"}, got.size(), n0 + 1);
        if (got.size() > n0) begin
            chk(nm, got[n0], exp);
            chk({nm, "_rdlat"}, got_cyc[n0] - acc, L);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int n0;
        int lows;
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_waitrequest", bus.avs_waitrequest_o, 1);
        chk("rst_valid", bus.avs_readdatavalid_o, 0);
        chk("rst_readdata", bus.avs_readdata_o, 16'h0);
        chk("rst_err", err, 0);

        issue(1'b0, 1'b1, 11'h010, 2'b11, 16'hA55A, 1'b0, lat, acc);
        idle();
        chk("wr_lat", lat, 3);
        rd_expect("rd_010", 11'h010, 16'hA55A);

        wr_word(11'h020, 2'b11, 16'h1234);
        wr_word(11'h020, 2'b01, 16'hFFFF);
        rd_expect("be01", 11'h020, 16'h12FF);
        wr_word(11'h020, 2'b00, 16'h0000);
        rd_expect("be00", 11'h020, 16'h12FF);

        wr_word(11'h001, 2'b11, 16'h1111);
        wr_word(11'h002, 2'b11, 16'h2222);
        wr_word(11'h003, 2'b11, 16'h3333);
        n0 = got.size();
        issue(1'b1, 1'b0, 11'h001, 2'b00, 16'h0, 1'b0, lat, acc);
        issue(1'b1, 1'b0, 11'h002, 2'b00, 16'h0, 1'b0, lat, acc);
        chk("b2b_lat", lat, 3);
        issue(1'b1, 1'b0, 11'h003, 2'b00, 16'h0, 1'b0, lat, acc);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_cnt", got.size(), n0 + 3);
        if (got.size() >= n0 + 3) begin
            chk("b2b_d0", got[n0], 16'h1111);
            chk("b2b_d1", got[n0+1], 16'h2222);
            chk("b2b_d2", got[n0+2], 16'h3333);
            chk("b2b_gap0", got_cyc[n0+1] - got_cyc[n0], 4);
            chk("b2b_gap1", got_cyc[n0+2] - got_cyc[n0+1], 4);
        end

        n0 = got.size();
        issue(1'b1, 1'b1, 11'h030, 2'b11, 16'hBEEF, 1'b0, lat, acc);
        idle();
        repeat (5) @(posedge clk);
        #1;
        chk("rw_novalid", got.size(), n0);
        chk("rw_err", err, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("rw_err_sticky", err, 1);
        rd_expect("rw_word", 11'h030, 16'hBEEF);
        do_reset();
        chk("err_cleared", err, 0);

        wr_word(11'h040, 2'b11, 16'h0BAD);
        rd_expect("pre_rst", 11'h040, 16'h0BAD);
        issue(1'b0, 1'b1, 11'h040, 2'b11, 16'h1111, 1'b1, lat, acc);
        idle();
        chk("rst_acc_wait", bus.avs_waitrequest_o, 1);
        chk("rst_acc_err", err, 0);
        n0 = got.size();
        issue(1'b1, 1'b0, 11'h040, 2'b00, 16'h0, 1'b0, lat, acc);
        idle();
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("rst_drop_rd", got.size(), n0);
        chk("rst_rdata", bus.avs_readdata_o, 16'h0);
        rd_expect("post_rst", 11'h040, 16'h0BAD);

        wr_word(11'h050, 2'b11, 16'h5555);
        do_reset();
        lows = 0;
        bus.avs_write_i = 1'b1;
        bus.avs_address_i = 11'h050;
        bus.avs_byteenable_i = 2'b11;
        bus.avs_writedata_i = 16'hAAAA;
        @(negedge clk);
        lows += int'(!bus.avs_waitrequest_o);
        @(posedge clk);
        #1;
        @(negedge clk);
        lows += int'(!bus.avs_waitrequest_o);
        @(posedge clk);
        #1;
        idle();
        repeat (4) begin
            @(negedge clk);
            lows += int'(!bus.avs_waitrequest_o);
        end
        @(posedge clk);
        #1;
        chk("abort_lows", lows, 0);
        chk("abort_err", err, 1);
        rd_expect("abort_mem", 11'h050, 16'h5555);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
